// File: rtl/pipe_ctrl_if.sv
// Stall-request / exception / redirect bundle between the pipeline stages and pipe_ctrl.
interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        wdog_timeout;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  // Pipeline side: raises requests, consumes stall/flush/redirect
  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, wdog_timeout, stall_cycles, flush_count
  );

  // Sequencer side
  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, wdog_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall merge, exception/eret flush + redirect with a masked
// recovery window, stall watchdog and performance counters.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR     = 32'h00000020,
  parameter int unsigned RECOVER_CYCLES = 2,
  parameter int unsigned WDOG_LIMIT     = 1024
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   bus
);

  localparam int unsigned WW = $clog2(WDOG_LIMIT) + 1;
  localparam logic [31:0] ERET_CODE = 32'h0000000e;

  typedef enum logic {RUN, RECOVER} state_t;

  state_t       state;
  logic [3:0]   rcnt;
  logic [WW-1:0] wcnt;
  logic [31:0]  new_pc_q;
  logic [31:0]  stall_cycles_q;
  logic [15:0]  flush_count_q;

  logic [5:0]   stall_req;
  logic         take;
  logic         wdog_fire;
  logic         flush_c;
  logic [5:0]   stall_c;
  logic [31:0]  target;

  // Merge per-stage requests: the deepest stalled stage freezes itself and everything upstream
  always_comb begin
    stall_req = '0;
    if (bus.stallreq_mem)      stall_req = 6'b011111;
    else if (bus.stallreq_ex)  stall_req = 6'b001111;
    else if (bus.stallreq_id)  stall_req = 6'b000111;
    else if (bus.stallreq_if)  stall_req = 6'b000011;
  end

  // Exception/watchdog decision; a pending exception behind a MEM stall is deferred, not dropped,
  // and an exception in the same cycle as a watchdog fire suppresses the timeout
  always_comb begin
    take      = !rst && (state == RUN) && (bus.excepttype_i != '0) && !bus.stallreq_mem;
    wdog_fire = !rst && (state == RUN) && !take && (stall_req != '0)
                && (wcnt == WW'(WDOG_LIMIT - 1));
    flush_c   = take || wdog_fire;
    stall_c   = (flush_c || rst) ? '0 : stall_req;
    target    = (take && (bus.excepttype_i == ERET_CODE)) ? bus.cp0_epc_i : EXC_VECTOR;
  end

  assign bus.stall        = stall_c;
  assign bus.flush        = flush_c;
  assign bus.new_pc       = flush_c ? target : new_pc_q;
  assign bus.wdog_timeout = wdog_fire;
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;

  // Sequencer state, recovery/watchdog counters, held redirect PC and perf counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      rcnt           <= '0;
      wcnt           <= '0;
      new_pc_q       <= '0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall_c != '0 && stall_cycles_q != '1)
        stall_cycles_q <= stall_cycles_q + 32'd1;

      if (state == RECOVER || flush_c || stall_c == '0)
        wcnt <= '0;
      else
        wcnt <= wcnt + WW'(1);

      case (state)
        RUN: begin
          if (flush_c) begin
            state         <= RECOVER;
            rcnt          <= 4'(RECOVER_CYCLES - 1);
            new_pc_q      <= target;
            flush_count_q <= flush_count_q + 16'd1;
          end
        end
        RECOVER: begin
          if (rcnt == '0) state <= RUN;
          else            rcnt  <= rcnt - 4'd1;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, syscall/eret/deferral flushes,
// watchdog and reset during recovery.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;

  pipe_ctrl_if bus();

  pipe_ctrl #(
    .EXC_VECTOR     (32'h00000020),
    .RECOVER_CYCLES (2),
    .WDOG_LIMIT     (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle, drive inputs just after the edge, settle before checking
  task automatic cyc(input logic r, input logic rif, input logic rid, input logic rex,
                     input logic rmem, input logic [31:0] exc, input logic [31:0] epc);
    @(posedge clk);
    #1;
    rst              = r;
    bus.stallreq_if  = rif;
    bus.stallreq_id  = rid;
    bus.stallreq_ex  = rex;
    bus.stallreq_mem = rmem;
    bus.excepttype_i = exc;
    bus.cp0_epc_i    = epc;
    #2;
  endtask

  initial begin
    bus.stallreq_if = 0; bus.stallreq_id = 0; bus.stallreq_ex = 0; bus.stallreq_mem = 0;
    bus.excepttype_i = '0; bus.cp0_epc_i = '0;

    // reset
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rst_stall", 32'(bus.stall), 0);
    chk("rst_flush", 32'(bus.flush), 0);
    chk("rst_newpc", bus.new_pc, 0);
    chk("rst_wdog", 32'(bus.wdog_timeout), 0);
    chk("rst_sc", bus.stall_cycles, 0);
    chk("rst_fc", 32'(bus.flush_count), 0);

    // stall priority
    cyc(0, 0, 1, 1, 0, 0, 0);
    chk("pri_id_ex", 32'(bus.stall), 32'h0f);
    chk("pri_sc0", bus.stall_cycles, 0);
    cyc(0, 0, 1, 1, 1, 0, 0);
    chk("pri_mem", 32'(bus.stall), 32'h1f);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("pri_none", 32'(bus.stall), 0);
    chk("pri_sc2", bus.stall_cycles, 2);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("pri_if", 32'(bus.stall), 32'h03);
    cyc(0, 1, 1, 0, 0, 0, 0);
    chk("pri_id", 32'(bus.stall), 32'h07);

    // syscall
    cyc(0, 0, 0, 0, 0, 32'h8, 0);
    chk("sys_flush", 32'(bus.flush), 1);
    chk("sys_newpc", bus.new_pc, 32'h20);
    chk("sys_stall", 32'(bus.stall), 0);
    chk("sys_fc0", 32'(bus.flush_count), 0);
    cyc(0, 0, 0, 0, 0, 32'h8, 0);
    chk("sys_rec1_flush", 32'(bus.flush), 0);
    chk("sys_fc1", 32'(bus.flush_count), 1);
    chk("sys_newpc_hold", bus.new_pc, 32'h20);
    cyc(0, 1, 0, 0, 0, 32'h8, 0);
    chk("sys_rec2_flush", 32'(bus.flush), 0);
    chk("sys_rec2_stall", 32'(bus.stall), 32'h03);
    cyc(0, 0, 0, 0, 0, 32'h8, 0);
    chk("sys_again_flush", 32'(bus.flush), 1);
    chk("sys_sc", bus.stall_cycles, 5);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("sys_fc2", 32'(bus.flush_count), 2);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // eret
    cyc(0, 0, 0, 0, 0, 32'he, 32'hBFC00100);
    chk("eret_flush", 32'(bus.flush), 1);
    chk("eret_newpc", bus.new_pc, 32'hBFC00100);
    cyc(0, 0, 0, 0, 0, 0, 32'h12345678);
    chk("eret_hold", bus.new_pc, 32'hBFC00100);
    chk("eret_fc", 32'(bus.flush_count), 3);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // deferral behind a MEM stall
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1, 32'hc, 0);
      chk("def_flush", 32'(bus.flush), 0);
      chk("def_stall", 32'(bus.stall), 32'h1f);
    end
    cyc(0, 0, 0, 0, 0, 32'hc, 0);
    chk("def_take_flush", 32'(bus.flush), 1);
    chk("def_take_newpc", bus.new_pc, 32'h20);
    chk("def_take_stall", 32'(bus.stall), 0);
    chk("def_sc", bus.stall_cycles, 8);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // watchdog: fires on the 8th consecutive stalled cycle
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 0, 1, 0, 0, 0);
      chk("wd1_quiet", 32'(bus.wdog_timeout), 0);
      chk("wd1_noflush", 32'(bus.flush), 0);
    end
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("wd1_fire", 32'(bus.wdog_timeout), 1);
    chk("wd1_flush", 32'(bus.flush), 1);
    chk("wd1_stall", 32'(bus.stall), 0);
    chk("wd1_newpc", bus.new_pc, 32'h20);
    chk("wd1_sc", bus.stall_cycles, 15);
    chk("wd1_fc", 32'(bus.flush_count), 4);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 1, 0, 0, 0);
      chk("wd_rec_quiet", 32'(bus.wdog_timeout), 0);
      chk("wd_rec_stall", 32'(bus.stall), 32'h0f);
    end
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 0, 1, 0, 0, 0);
      chk("wd2_quiet", 32'(bus.wdog_timeout), 0);
    end
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("wd2_fire", 32'(bus.wdog_timeout), 1);
    chk("wd2_sc", bus.stall_cycles, 24);
    chk("wd2_fc", 32'(bus.flush_count), 5);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // a single stall-free cycle restarts the count
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 0, 1, 0, 0, 0);
      chk("wd3_quiet", 32'(bus.wdog_timeout), 0);
    end
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("wd3_fire", 32'(bus.wdog_timeout), 1);
    chk("wd3_sc", bus.stall_cycles, 37);
    chk("wd3_fc", 32'(bus.flush_count), 6);

    // reset in the middle of the recovery window
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 32'h8, 0);
    chk("rr_sc", bus.stall_cycles, 0);
    chk("rr_fc", 32'(bus.flush_count), 0);
    chk("rr_flush", 32'(bus.flush), 1);
    chk("rr_newpc", bus.new_pc, 32'h20);
    chk("rr_wdog", 32'(bus.wdog_timeout), 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rr_fc1", 32'(bus.flush_count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
